// File: rtl/ff_bank_pkg.sv
// Shared types and helpers for the flip-flop bank write arbiter.
// Pure declarations: no latency, no flow control.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } state_t;

  localparam int MAX_AW    = 8;
  localparam int MAX_DEPTH = 1 << MAX_AW;

  // Returns the widest supported enable vector; callers keep the low DEPTH bits.
  function automatic logic [MAX_DEPTH-1:0] onehot(input logic [MAX_AW-1:0] addr);
    logic [MAX_DEPTH-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ff_bank_write_arbiter_rr_picker.sv
// Round-robin requester picker: first set req bit at or above ptr, wrapping.
// Purely combinational (zero latency); no backpressure, the caller samples it when idle.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            vld_o,
  output logic [IW-1:0]   idx_o
);

  int cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_i) + i) % NREQ;
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/ff_bank_write_arbiter.sv
// Round-robin arbiter for the single write port of a falling-edge flip-flop bank; one write per 3 clocks.
// Grant drives bank_en for one cycle, then a four-phase req/ack; requests arriving while busy wait for IDLE.
module ff_bank_write_arbiter
  import ff_bank_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       ack,
  output logic [DEPTH-1:0]      bank_en,
  output logic [WIDTH-1:0]      bank_d,
  output logic                  busy,
  output logic [IW-1:0]         owner
);

  state_t              state_q;
  logic [NREQ-1:0]     ack_q;
  logic [DEPTH-1:0]    bank_en_q;
  logic [WIDTH-1:0]    bank_d_q;
  logic                busy_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       ptr_q;

  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic [AW-1:0]       sel_addr;
  logic [WIDTH-1:0]    sel_dat;
  logic [MAX_DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0]    bank_en_d;
  logic [IW-1:0]       ptr_d;
  logic [NREQ-1:0]     ack_d;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_dat  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr = addr[i*AW +: AW];
        sel_dat  = wdata[i*WIDTH +: WIDTH];
      end
    end
    sel_oh    = onehot(MAX_AW'(sel_addr));
    bank_en_d = sel_oh[DEPTH-1:0];
    ptr_d     = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;
    ack_d     = '0;
    ack_d[owner_q] = 1'b1;
  end

  // Bits above DEPTH are structurally zero for any in-range address.
  if (DEPTH < MAX_DEPTH) begin : g_oh_hi
    logic unused_oh_hi;
    assign unused_oh_hi = |sel_oh[MAX_DEPTH-1:DEPTH];
  end

  // Falling-edge state to line up with the bank's capture edge.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      bank_en_q <= '0;
      bank_d_q  <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            bank_d_q  <= sel_dat;
            owner_q   <= pick_idx;
            bank_en_q <= bank_en_d;
            busy_q    <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          bank_en_q <= '0;
          ack_q     <= ack_d;
          ptr_q     <= ptr_d;
          state_q   <= ACK;
        end
        ACK: begin
          if (!req[owner_q]) begin
            ack_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q     <= '0;
          bank_en_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ack     = ack_q;
  assign bank_en = bank_en_q;
  assign bank_d  = bank_d_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_ff_bank_write_arbiter.sv
// Bench for ff_bank_write_arbiter: directed scenarios then random legal requesters vs. a transaction-level model.
module tb_ff_bank_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int IW    = 2;

  logic                  clk = 1'b1;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*AW-1:0]    addr = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       ack;
  logic [DEPTH-1:0]      bank_en;
  logic [WIDTH-1:0]      bank_d;
  logic                  busy;
  logic [IW-1:0]         owner;

  ff_bank_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .addr    (addr),
    .wdata   (wdata),
    .ack     (ack),
    .bank_en (bank_en),
    .bank_d  (bank_d),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  // Bank model: falling-edge, enable-gated, async-clear words.
  logic [WIDTH-1:0] bank_mem [DEPTH];
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < DEPTH; w++) bank_mem[w] <= '0;
    end else begin
      for (int w = 0; w < DEPTH; w++) if (bank_en[w]) bank_mem[w] <= bank_d;
    end
  end

  // Reference model: where we are in the current transaction and what it should show.
  int               m_phase;   // 0 waiting for a grant, 1 write cycle, 2 acknowledging
  int               m_owner;
  int               m_ptr;
  logic [NREQ-1:0]  m_ack;
  logic [DEPTH-1:0] m_en;
  logic [WIDTH-1:0] m_d;
  logic [WIDTH-1:0] exp_mem [DEPTH];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0;
    m_ack = '0; m_en = '0; m_d = '0;
    for (int w = 0; w < DEPTH; w++) exp_mem[w] = '0;
  endtask

  task automatic check_all();
    chk("ack", 32'(ack), 32'(m_ack));
    chk("bank_en", 32'(bank_en), 32'(m_en));
    chk("bank_d", 32'(bank_d), 32'(m_d));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("owner", 32'(owner), 32'(m_owner));
  endtask

  // One falling edge: model advances on the inputs seen at that edge, then outputs are compared.
  task automatic tick();
    logic [NREQ-1:0]       r;
    logic [NREQ*AW-1:0]    a;
    logic [NREQ*WIDTH-1:0] d;
    int                    found;
    int                    aa;
    r = req; a = addr; d = wdata;
    @(negedge clk);
    #1;
    case (m_phase)
      0: begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (found == 0 && r[(m_ptr + k) % NREQ]) begin
            found   = 1;
            m_owner = (m_ptr + k) % NREQ;
          end
        end
        if (found == 1) begin
          aa           = int'(a[m_owner*AW +: AW]);
          m_d          = d[m_owner*WIDTH +: WIDTH];
          m_en         = '0;
          m_en[aa]     = 1'b1;
          exp_mem[aa]  = m_d;
          m_phase      = 1;
        end
      end
      1: begin
        m_en           = '0;
        m_ack          = '0;
        m_ack[m_owner] = 1'b1;
        m_ptr          = (m_owner + 1) % NREQ;
        m_phase        = 2;
      end
      default: begin
        if (!r[m_owner]) begin
          m_ack   = '0;
          m_phase = 0;
        end
      end
    endcase
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    #1;
    model_reset();
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input int a, input int d);
    addr[i*AW +: AW]     = AW'(a);
    wdata[i*WIDTH +: WIDTH] = WIDTH'(d);
    req[i]               = 1'b1;
  endtask

  task automatic drain();
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREQ; i++) if (req[i] && m_ack[i]) req[i] = 1'b0;
      tick();
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  int g_owner [5];
  int g_tick  [5];
  int n_grant;
  int ack_cnt;

  initial begin
    model_reset();
    #2;
    do_reset();

    // Single request: addr 3, data A5.
    set_req(0, 3, 8'hA5);
    tick();
    chk("t1_en", 32'(bank_en), 32'h08);
    chk("t1_d", 32'(bank_d), 32'hA5);
    chk("t1_ack_low", 32'(ack), 32'h0);
    tick();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_en_clr", 32'(bank_en), 32'h0);
    chk("t1_owner", 32'(owner), 32'h0);
    req[0] = 1'b0;
    tick();
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_mem", 32'(bank_mem[3]), 32'hA5);

    // All four requesting continuously: strict rotation, 3 edges apart.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(DEPTH-1), $urandom_range(255));
    n_grant = 0;
    for (int g = 0; g < 5; g++) begin g_owner[g] = -1; g_tick[g] = -1; end
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && m_ack[i]) req[i] = 1'b0;
        else if (!req[i] && !m_ack[i]) set_req(i, $urandom_range(DEPTH-1), $urandom_range(255));
      end
      tick();
      if (bank_en != '0 && n_grant < 5) begin
        g_owner[n_grant] = int'(owner);
        g_tick[n_grant]  = t;
        n_grant++;
      end
    end
    for (int g = 0; g < 5; g++) chk("t2_order", 32'(g_owner[g]), 32'(g % NREQ));
    for (int g = 1; g < 5; g++) chk("t2_spacing", 32'(g_tick[g] - g_tick[g-1]), 32'd3);
    req = '0;
    drain();

    // Winner withdraws during the write cycle.
    set_req(1, 5, 8'h3C);
    tick();
    req[1] = 1'b0;
    ack_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      ack_cnt += int'(ack[1]);
    end
    chk("t3_ack_cycles", 32'(ack_cnt), 32'd1);
    chk("t3_mem", 32'(bank_mem[5]), 32'h3C);

    // A request raised during another's ACK waits and is granted next.
    set_req(2, 2, 8'h77);
    tick();
    tick();
    set_req(1, 6, 8'h99);
    tick();
    tick();
    req[2] = 1'b0;
    tick();
    tick();
    chk("t4_owner", 32'(owner), 32'd1);
    chk("t4_en", 32'(bank_en), 32'h40);
    drain();
    chk("t4_mem2", 32'(bank_mem[2]), 32'h77);
    chk("t4_mem6", 32'(bank_mem[6]), 32'h99);

    // Asynchronous reset in the middle of a write cycle.
    set_req(3, 1, 8'h5A);
    tick();
    chk("t5_en_pre", 32'(bank_en), 32'h02);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_en_async", 32'(bank_en), 32'h0);
    chk("t5_ack_async", 32'(ack), 32'h0);
    chk("t5_busy_async", 32'(busy), 32'h0);
    chk("t5_mem_clr", 32'(bank_mem[1]), 32'h0);
    model_reset();
    req = '0;
    @(negedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, i, 8'h10 + i);
    tick();
    chk("t5_ptr0", 32'(owner), 32'd0);
    drain();

    // Random legal requesters.
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !m_ack[i]) begin
          if ($urandom_range(3) == 0) set_req(i, $urandom_range(DEPTH-1), $urandom_range(255));
        end else if (req[i] && m_ack[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end else if (req[i] && m_phase == 1 && m_owner == i) begin
          if ($urandom_range(7) == 0) req[i] = 1'b0;
        end
      end
      tick();
    end
    drain();
    for (int w = 0; w < DEPTH; w++) chk("mem", 32'(bank_mem[w]), 32'(exp_mem[w]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
